bram_port_client: RTL and testbench

Initiator for one port of the dual-port write-first BRAM. It takes read/write requests on a valid/ready interface and drives the BRAM port pins (EN/WE/ADDR/DI). It tracks in-flight reads across the BRAM's fixed 1- or 2-cycle latency and returns read data through a credit-protected response FIFO with valid/ready. It sits between a client engine (DMA, table walker) and one BRAM port, so clients never have to count memory latency themselves.

---
 rtl/bram_client_pkg.sv | 23 ++
 rtl/bram_port_client_if.sv | 34 +++
 rtl/bram_client_resp_fifo.sv | 60 ++++++
 rtl/bram_port_client.sv | 119 +++++++++++
 tb/tb_bram_port_client.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bram_client_pkg.sv
// Shared helpers for bram_port_client: read latency, credit width, response entry width.
// BRAM_CLIENT_WRACK_EN adds a write-acknowledge tag bit to every response entry.
package bram_client_pkg;

`ifdef BRAM_CLIENT_WRACK_EN
  localparam int RESP_TAG_W = 1;
`else
  localparam int RESP_TAG_W = 0;
`endif

  function automatic int read_latency(input int pipelined);
    return 1 + pipelined;
  endfunction

  function automatic int credit_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int resp_entry_width(input int data_w);
    return data_w + RESP_TAG_W;
  endfunction

endpackage

// File: rtl/bram_port_client_if.sv
// Client-side request/response channel of bram_port_client.
// resp_wrack exists only when BRAM_CLIENT_WRACK_EN is defined.
interface bram_port_client_if #(
  parameter int ADDR_WIDTH = 1,
  parameter int DATA_WIDTH = 1
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_data;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_data;
`ifdef BRAM_CLIENT_WRACK_EN
  logic                  resp_wrack;
`endif

  modport master (
    output req_valid, req_write, req_addr, req_data, resp_ready,
`ifdef BRAM_CLIENT_WRACK_EN
    input  resp_wrack,
`endif
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_data, resp_ready,
`ifdef BRAM_CLIENT_WRACK_EN
    output resp_wrack,
`endif
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/bram_client_resp_fifo.sv
// Synchronous response FIFO for bram_port_client; DEPTH must be a power of two (>= 2).
// A push while full is accepted only if a pop happens in the same cycle.
module bram_client_resp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             valid_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop_i && (count_q != '0);
    do_push  = push_i && ((count_q != DEPTH_C) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign pop_data_o = mem_q[rd_ptr_q];
  assign valid_o    = (count_q != '0);
  assign full_o     = (count_q == DEPTH_C);
  assign empty_o    = (count_q == '0);
endmodule

// File: rtl/bram_port_client.sv
// Single-port BRAM initiator: issues requests, tracks the fixed read latency, returns data in order.
// Optional BRAM_CLIENT_WRACK_EN: writes consume a credit and return a write-acknowledge response.
module bram_port_client
  import bram_client_pkg::*;
#(
  parameter int ADDR_WIDTH = 1,
  parameter int DATA_WIDTH = 1,
  parameter int PIPELINED  = 1,
  parameter int RESP_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  bram_port_client_if.slave     bus,
  output logic                  mem_en_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_di_o,
  input  logic [DATA_WIDTH-1:0] mem_do_i,
  input  logic                  mem_dr_i
);
  localparam int L  = read_latency(PIPELINED);
  localparam int CW = credit_width(RESP_DEPTH);
  localparam int EW = resp_entry_width(DATA_WIDTH);
  localparam logic [CW-1:0] FULL_CREDITS = CW'(RESP_DEPTH);

  typedef struct packed {
`ifdef BRAM_CLIENT_WRACK_EN
    logic                  wrack;
`endif
    logic [DATA_WIDTH-1:0] data;
  } resp_entry_t;

  logic [CW-1:0] credits_q, credits_d;
  logic [L-1:0]  trk_q, trk_d;
  logic          needs_credit, ready, xfer, issue, pop, push;
  logic          fifo_valid, fifo_full, fifo_empty;
  resp_entry_t   push_entry, pop_entry;
`ifdef BRAM_CLIENT_WRACK_EN
  logic [L-1:0]  tag_q, tag_d;
`endif

  always_comb begin
`ifdef BRAM_CLIENT_WRACK_EN
    needs_credit = 1'b1;
`else
    needs_credit = !bus.req_write;
`endif
    ready     = !rst && (!needs_credit || (credits_q != '0));
    xfer      = bus.req_valid && ready;
    issue     = xfer && needs_credit;
    credits_d = credits_q;
    if (issue && !pop)      credits_d = credits_q - 1'b1;
    else if (pop && !issue) credits_d = credits_q + 1'b1;
    // Tail of the shift register marks the cycle the BRAM presents the data; DR is not a strobe.
    trk_d    = trk_q << 1;
    trk_d[0] = issue;
    push     = trk_q[L-1];
    push_entry.data = mem_do_i;
`ifdef BRAM_CLIENT_WRACK_EN
    tag_d    = tag_q << 1;
    tag_d[0] = bus.req_write;
    push_entry.wrack = tag_q[L-1];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credits_q <= FULL_CREDITS;
      trk_q     <= '0;
    end else begin
      credits_q <= credits_d;
      trk_q     <= trk_d;
    end
  end

`ifdef BRAM_CLIENT_WRACK_EN
  always_ff @(posedge clk) begin
    tag_q <= tag_d;
  end
`endif

  bram_client_resp_fifo #(
    .WIDTH (EW),
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .pop_data_o  (pop_entry),
    .valid_o     (fifo_valid),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign bus.req_ready  = ready;
  assign mem_en_o       = xfer;
  assign mem_we_o       = xfer && bus.req_write;
  assign mem_addr_o     = bus.req_addr;
  assign mem_di_o       = bus.req_data;
  assign bus.resp_valid = fifo_valid && !rst;
  assign bus.resp_data  = pop_entry.data;
  assign pop            = bus.resp_valid && bus.resp_ready;
`ifdef BRAM_CLIENT_WRACK_EN
  assign bus.resp_wrack = bus.resp_valid && pop_entry.wrack;
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst && push && !mem_dr_i)
      $error("bram_port_client: tracked BRAM response arrived with DR low");
    if (!rst && push && fifo_full && !pop)
      $error("bram_port_client: response FIFO overflow, credit accounting broken");
    if (!rst && pop && fifo_empty)
      $error("bram_port_client: pop from empty response FIFO");
  end
`endif
endmodule

// File: tb/tb_bram_port_client.sv
// Scoreboard bench for bram_port_client against a behavioural BRAM and an issue-order reference model.
module tb_bram_port_client;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int P  = 1;
  localparam int RD = 4;
  localparam int L  = 1 + P;
`ifdef BRAM_CLIENT_WRACK_EN
  localparam bit WRACK = 1'b1;
`else
  localparam bit WRACK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bram_port_client_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  logic          mem_en, mem_we, mem_dr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_di, mem_do;

  bram_port_client #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .PIPELINED  (P),
    .RESP_DEPTH (RD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .mem_en_o   (mem_en),
    .mem_we_o   (mem_we),
    .mem_addr_o (mem_addr),
    .mem_di_o   (mem_di),
    .mem_do_i   (mem_do),
    .mem_dr_i   (mem_dr)
  );

  // Write-first BRAM with optional output register; DR is set on first output and then held.
  logic [DW-1:0] bram [16];
  logic [DW-1:0] s1_d, do_q;
  logic          s1_v = 1'b0, dr1 = 1'b0, dr_q = 1'b0;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) bram[mem_addr] <= mem_di;
      s1_d <= mem_we ? mem_di : bram[mem_addr];
      dr1  <= 1'b1;
    end
    s1_v <= mem_en;
    if (s1_v) begin
      do_q <= s1_d;
      dr_q <= 1'b1;
    end
  end
  assign mem_do = (P != 0) ? do_q : s1_d;
  assign mem_dr = (P != 0) ? dr_q : dr1;

  typedef struct {
    bit            wr;
    logic [DW-1:0] d;
    int            cyc;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  logic [DW-1:0] ref_mem [16];
  int            cyc = 0;
  int            checks = 0;
  int            errs = 0;
  int            n_resp = 0;
  bit            strict = 1'b0;
  bit            rr = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor: pops the expected queue whenever a response transfers.
  always @(negedge clk) begin
    if (bus.resp_valid && bus.resp_ready) begin
      n_resp++;
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("resp_data", 32'(bus.resp_data), 32'(mon_e.d));
`ifdef BRAM_CLIENT_WRACK_EN
        chk("resp_wrack", 32'(bus.resp_wrack), 32'(mon_e.wr));
`endif
        if (strict) chk("resp_latency", 32'(cyc - mon_e.cyc), 32'(L + 1));
      end
    end
  end

  // One clock cycle of stimulus; checks issue-side outputs and records expected responses.
  task automatic cycle(input bit v, input bit w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input bit r, output bit acc);
    bit exp_rdy;
    @(posedge clk);
    #1;
    rst            = r;
    bus.req_valid  = v;
    bus.req_write  = w;
    bus.req_addr   = a;
    bus.req_data   = d;
    bus.resp_ready = rr;
    #1;
    if (r)                exp_rdy = 1'b0;
    else if (!w || WRACK) exp_rdy = (exp_q.size() < RD);
    else                  exp_rdy = 1'b1;
    chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    acc = v && exp_rdy;
    chk("mem_en", 32'(mem_en), 32'(acc));
    chk("mem_we", 32'(mem_we), 32'(acc && w));
    if (r || exp_q.size() == 0) chk("resp_valid_idle", 32'(bus.resp_valid), 32'd0);
`ifdef BRAM_CLIENT_WRACK_EN
    if (r) chk("resp_wrack_rst", 32'(bus.resp_wrack), 32'd0);
`endif
    if (acc) begin
      chk("mem_addr", 32'(mem_addr), 32'(a));
      if (w) begin
        chk("mem_di", 32'(mem_di), 32'(d));
        ref_mem[a] = d;
        if (WRACK) exp_q.push_back('{1'b1, d, cyc});
      end else begin
        exp_q.push_back('{1'b0, ref_mem[a], cyc});
      end
    end
    if (r) exp_q.delete();
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, '0, 1'b0, acc);
  endtask

  task automatic issue(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit acc = 1'b0;
    int n = 0;
    while (!acc && n < 50) begin
      cycle(1'b1, w, a, d, 1'b0, acc);
      n++;
    end
    if (!acc) chk("issue_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    bit acc;
    int n = 0;
    rr = 1'b1;
    while (exp_q.size() != 0 && n < 60) begin
      cycle(1'b0, 1'b0, '0, '0, 1'b0, acc);
      n++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit            acc;
    int            cnt, base, idx;
    logic [AW-1:0] bp_addr [6];

    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_addr   = '0;
    bus.req_data   = '0;
    bus.resp_ready = 1'b1;

    // Reset: request offered but must not issue.
    repeat (3) cycle(1'b1, 1'b0, '0, '0, 1'b1, acc);
    cycle(1'b0, 1'b0, '0, '0, 1'b0, acc);

    for (int i = 0; i < 16; i++) issue(1'b1, AW'(i), DW'($urandom));
    drain();

    // Read latency after a write to the same address.
    issue(1'b1, AW'(3), 8'hA5);
    drain();
    strict = 1'b1;
    base = n_resp;
    issue(1'b0, AW'(3), '0);
    idle(L + 3);
    chk("lat_resp_count", 32'(n_resp - base), 32'd1);
    strict = 1'b0;

    // Back-to-back reads at full rate.
    strict = 1'b1;
    base = n_resp;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b0, AW'(i), '0, 1'b0, acc);
      cnt += int'(acc);
    end
    chk("b2b_accepted", 32'(cnt), 32'd8);
    idle(L + 2);
    chk("b2b_resp_count", 32'(n_resp - base), 32'd8);
    strict = 1'b0;

    // Backpressure: only RESP_DEPTH reads fit while the response side is stalled.
    drain();
    for (int i = 0; i < 6; i++) bp_addr[i] = AW'($urandom);
    rr = 1'b0;
    idx = 0;
    repeat (10) begin
      cycle(1'b1, 1'b0, bp_addr[idx], '0, 1'b0, acc);
      if (acc) idx++;
    end
    chk("bp_accepted", 32'(idx), 32'd4);
    rr = 1'b1;
    cnt = 0;
    while (idx < 6 && cnt < 40) begin
      cycle(1'b1, 1'b0, bp_addr[idx], '0, 1'b0, acc);
      if (acc) idx++;
      cnt++;
    end
    chk("bp_all_issued", 32'(idx), 32'd6);
    drain();

    // One read followed by idle cycles with DR held high.
    strict = 1'b1;
    base = n_resp;
    issue(1'b0, AW'($urandom), '0);
    idle(5 + L);
    chk("dr_hold_resp_count", 32'(n_resp - base), 32'd1);
    strict = 1'b0;

    // Reset with two reads in flight.
    drain();
    base = n_resp;
    cycle(1'b1, 1'b0, AW'(5), '0, 1'b0, acc);
    cycle(1'b1, 1'b0, AW'(6), '0, 1'b0, acc);
    cycle(1'b0, 1'b0, '0, '0, 1'b1, acc);
    idle(5);
    chk("rst_no_resp", 32'(n_resp - base), 32'd0);
    rr = 1'b0;
    cnt = 0;
    repeat (6) begin
      cycle(1'b1, 1'b0, AW'($urandom), '0, 1'b0, acc);
      cnt += int'(acc);
    end
    chk("rst_credits", 32'(cnt), 32'd4);
    drain();
    strict = 1'b1;
    base = n_resp;
    issue(1'b0, AW'(2), '0);
    idle(L + 3);
    chk("rst_new_read", 32'(n_resp - base), 32'd1);
    strict = 1'b0;

`ifdef BRAM_CLIENT_WRACK_EN
    // Write acknowledge carries the written data.
    drain();
    strict = 1'b1;
    base = n_resp;
    issue(1'b1, AW'(1), 8'h3C);
    idle(L + 3);
    chk("wrack_resp_count", 32'(n_resp - base), 32'd1);
    strict = 1'b0;
`endif

    // Random mixed traffic with random response backpressure.
    drain();
    repeat (300) begin
      rr = ($urandom_range(0, 3) != 0);
      cycle($urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0,
            AW'($urandom), DW'($urandom), 1'b0, acc);
    end
    drain();
    chk("final_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", checks, errs);
    $finish;
  end
endmodule
